fp_div_iter: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider (radix-2 restoring mantissa division) with a start/done handshake.
- Produces the quotient operand consumed directly by the downstream FloatingAddition stage in the division datapath.
- Registered outputs with fixed latency, so the adder sees a stable operand and flag set.
- Truncating (round-toward-zero) mantissa, matching the adder's truncation.

---
 rtl/fp_div_iter.sv | 136 +++++++++++++
 tb/tb_fp_div_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 single-precision divider: radix-2 restoring mantissa
// division, truncating result, fixed 26-cycle start-to-done latency.
module fp_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  // Handshake: start is taken only on an edge where busy=0 (including the
  // done cycle); done pulses for one cycle with result/flags valid, and
  // result/flags then hold until the next done or reset.

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t      state;
  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [25:0] rem;
  logic [25:0] divisor;
  logic [24:0] q;
  logic [4:0]  cnt;

  logic [25:0]       trial;
  logic              q_bit;
  logic signed [9:0] e_val;
  logic [22:0]       mant;
  logic [31:0]       res_next;
  logic              ovf_next;
  logic              unf_next;
  logic              exc_next;

  assign trial = rem - divisor;
  assign q_bit = (rem >= divisor);

  // q[24] set means the quotient mantissa is in [1,2) already; otherwise
  // it sits in [0.5,1) and the exponent absorbs the one-bit shift.
  always_comb begin
    e_val = '0;
    mant  = '0;
    if (q[24]) begin
      e_val = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
      mant  = q[23:1];
    end else begin
      e_val = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
      mant  = q[22:0];
    end
  end

  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    exc_next = 1'b0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      res_next = 32'h7FC0_0000;
      exc_next = 1'b1;
    end else if (eb == 8'h00) begin
      res_next = (ea != 8'h00) ? {sign, 8'hFF, 23'h0} : 32'h7FC0_0000;
      exc_next = 1'b1;
    end else if (ea == 8'h00) begin
      res_next = {sign, 31'h0};
    end else if (e_val >= 10'sd255) begin
      res_next = {sign, 8'hFF, 23'h0};
      ovf_next = 1'b1;
    end else if (e_val <= 10'sd0) begin
      res_next = {sign, 31'h0};
      unf_next = 1'b1;
    end else begin
      res_next = {sign, e_val[7:0], mant};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
      sign      <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      rem       <= '0;
      divisor   <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign    <= A[31] ^ B[31];
            ea      <= A[30:23];
            eb      <= B[30:23];
            rem     <= {2'b00, 1'b1, A[22:0]};
            divisor <= {2'b00, 1'b1, B[22:0]};
            q       <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          q   <= {q[23:0], q_bit};
          rem <= q_bit ? {trial[24:0], 1'b0} : {rem[24:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) state <= NORM;
        end
        NORM: begin
          result    <= res_next;
          overflow  <= ovf_next;
          underflow <= unf_next;
          exception <= exc_next;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: hand-computed quotients, special cases,
// latency, back-to-back start, ignored start while busy, mid-op reset.
module tb_fp_div_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        exception;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  exp_flags_q[$];

  fp_div_iter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .exception(exception)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driven and sampled on the falling edge; the start edge is the next rise.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [2:0] exp_flags);
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back(exp_res);
    exp_flags_q.push_back(exp_flags);
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic score(input string tag, input int lat);
    logic [31:0] er;
    logic [2:0]  ef;
    check({tag, "_lat"}, lat, 26);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      er = exp_q.pop_front();
      ef = exp_flags_q.pop_front();
      check({tag, "_done"}, {31'h0, done}, 32'h1);
      check({tag, "_res"}, result, er);
      check({tag, "_flags"}, {29'h0, overflow, underflow, exception}, {29'h0, ef});
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic [2:0] exp_flags);
    int lat;
    issue(a, b, exp_res, exp_flags);
    wait_done(lat);
    score(tag, lat);
    @(negedge clk);
    check({tag, "_pulse"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    int lat;
    int dones;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {busy, done, overflow, underflow, exception}, 5'b0);
    check("rst_res", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // flags are {overflow, underflow, exception}
    run("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);

    // 1/3 then -7.5/2.5 started in the done cycle
    issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000);
    wait_done(lat);
    score("one_third", lat);
    issue(32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 3'b000);
    check("b2b_busy", {31'h0, busy}, 32'h1);
    wait_done(lat);
    score("b2b_neg", lat);
    @(negedge clk);

    run("div_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b001);
    run("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001);
    run("inf_op", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b001);
    run("ovf", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 3'b100);
    run("unf", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 3'b010);
    run("zero_num", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3'b000);

    // start re-asserted at cycle 10 of a busy division must be ignored
    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
    dones = 0;
    lat = 0;
    repeat (9) begin
      @(negedge clk);
      lat++;
    end
    A = 32'h3F80_0000;
    B = 32'h0000_0000;
    start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    score("ignored_start", lat);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignored_extra_done", dones, 0);

    // reset at cycle 12 aborts the division
    issue(32'h3F80_0000, 32'h4040_0000, 32'h0, 3'b000);
    void'(exp_q.pop_back());
    void'(exp_flags_q.pop_back());
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outs", {busy, done, overflow, underflow, exception}, 5'b0);
    check("midrst_res", result, 32'h0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run("after_rst", 32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
